// File: rtl/alu_arbiter.sv
// alu_arbiter
//   Two-requester front end for a single shared combinational ALU. A round-robin
//   arbiter accepts one operation at a time, registers its operands and op code
//   onto the ALU inputs, waits one cycle (DIV_WAIT cycles for the long
//   multiply/divide/modulo codes), captures the ALU result and holds it as a
//   response until the consumer takes it.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   reqN_valid / reqN_ready   requester N handshake (ready is combinational)
//   reqN_in1, reqN_in2        requester N operands
//   reqN_op                   requester N one-hot ALU op code
//   alu_in1, alu_in2          registered operands to the shared ALU
//   alu_instructions          registered op code to the shared ALU
//   alu_result                combinational ALU output
//   rsp_valid / rsp_ready     response handshake
//   rsp_id                    index of the requester owning the response
//   rsp_data                  captured ALU result
//   busy                      high whenever an operation is in flight
module alu_arbiter #(
  parameter int DIV_WAIT = 4,
  parameter int DATA_W   = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req0_valid,
  output logic                req0_ready,
  input  logic [DATA_W-1:0]   req0_in1,
  input  logic [DATA_W-1:0]   req0_in2,
  input  logic [15:0]         req0_op,
  input  logic                req1_valid,
  output logic                req1_ready,
  input  logic [DATA_W-1:0]   req1_in1,
  input  logic [DATA_W-1:0]   req1_in2,
  input  logic [15:0]         req1_op,
  output logic [DATA_W-1:0]   alu_in1,
  output logic [DATA_W-1:0]   alu_in2,
  output logic [15:0]         alu_instructions,
  input  logic [2*DATA_W-1:0] alu_result,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic                rsp_id,
  output logic [2*DATA_W-1:0] rsp_data,
  output logic                busy
);

  localparam int CNT_W = 5;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t             state, state_nxt;
  logic               last;
  logic               owner;
  logic [CNT_W-1:0]   cnt;
  logic               grant0, grant1;
  logic               accept;
  logic               sel;
  logic [15:0]        sel_op;
  logic               done;

  // Multiply, divide and modulo need the full DIV_WAIT settling time.
  function automatic logic is_long_op(input logic [15:0] op);
    return (op == 16'd1024) || (op == 16'd2048) || (op == 16'd4096);
  endfunction

  // last holds the previous winner, so a tie goes to the other requester.
  assign grant0 = req0_valid && (!req1_valid || last);
  assign grant1 = req1_valid && (!req0_valid || !last);

  // Ready is suppressed during reset so no accept can coincide with it.
  assign req0_ready = (state == IDLE) && grant0 && !rst;
  assign req1_ready = (state == IDLE) && grant1 && !rst;
  assign accept     = req0_ready || req1_ready;
  assign sel        = req1_ready;
  assign sel_op     = sel ? req1_op : req0_op;
  assign done       = (state == EXEC) && (cnt == CNT_W'(1));

  assign rsp_valid  = (state == RESP);
  assign rsp_id     = owner;
  assign busy       = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)    state_nxt = EXEC;
      EXEC:    if (done)      state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // Accept stage: operands onto the ALU; execute stage: count down, capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      last             <= 1'b1;
      owner            <= 1'b0;
      cnt              <= '0;
      alu_in1          <= '0;
      alu_in2          <= '0;
      alu_instructions <= '0;
      rsp_data         <= '0;
    end else if (accept) begin
      alu_in1          <= sel ? req1_in1 : req0_in1;
      alu_in2          <= sel ? req1_in2 : req0_in2;
      alu_instructions <= sel_op;
      owner            <= sel;
      last             <= sel;
      cnt              <= is_long_op(sel_op) ? CNT_W'(DIV_WAIT) : CNT_W'(1);
    end else if (state == EXEC) begin
      cnt <= cnt - CNT_W'(1);
      if (done) begin
        rsp_data <= alu_result;
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: a behavioural ALU drives alu_result, a
// reference model predicts grants, response order, latency and data, and a
// monitor compares the DUT against a scoreboard queue every cycle.
module tb_alu_arbiter;

  localparam int DW = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_in1, req0_in2, req1_in1, req1_in2;
  logic [15:0] req0_op, req1_op;
  logic [31:0] alu_in1, alu_in2;
  logic [15:0] alu_instructions;
  logic [63:0] alu_result;
  logic        rsp_valid, rsp_ready, rsp_id;
  logic [63:0] rsp_data;
  logic        busy;

  alu_arbiter #(.DIV_WAIT(DW), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_in1(req0_in1), .req0_in2(req0_in2), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_in1(req1_in1), .req1_in2(req1_in2), .req1_op(req1_op),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_instructions(alu_instructions),
    .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] aluf(input logic [31:0] a, input logic [31:0] b,
                                       input logic [15:0] op);
    logic [63:0] ea, eb;
    ea = {32'b0, a};
    eb = {32'b0, b};
    case (op)
      16'd1:    return ea + eb;
      16'd2:    return ea - eb;
      16'd4:    return ea ^ eb;
      16'd8:    return ea | eb;
      16'd16:   return ea & eb;
      16'd32:   return ea << b[4:0];
      16'd1024: return ea * eb;
      16'd2048: return (b == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : ea / eb;
      16'd4096: return (b == 0) ? ea : ea % eb;
      default:  return 64'd0;
    endcase
  endfunction

  always_comb alu_result = aluf(alu_in1, alu_in2, alu_instructions);

  typedef struct {
    logic        id;
    logic [63:0] data;
    logic [31:0] a;
    logic [15:0] op;
    int          due;
    bit          seen;
  } entry_t;

  entry_t sb[$];
  int     n_cmp = 0;
  int     n_fail = 0;
  int     cyc = 0;
  logic   m_inflight = 1'b0;
  logic   m_last = 1'b1;
  logic   post_rst = 1'b0;
  logic   e0, e1;
  entry_t en;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit is_long(input logic [15:0] op);
    return op == 16'd1024 || op == 16'd2048 || op == 16'd4096;
  endfunction

  // Monitor / reference model, evaluated mid-cycle on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      check("ready_in_reset", {62'b0, req0_ready, req1_ready}, 64'd0);
      sb.delete();
      m_inflight = 1'b0;
      m_last     = 1'b1;
      post_rst   = 1'b1;
    end else begin
      if (post_rst) begin
        check("rst_alu_in1", {32'b0, alu_in1}, 64'd0);
        check("rst_alu_in2", {32'b0, alu_in2}, 64'd0);
        check("rst_alu_instr", {48'b0, alu_instructions}, 64'd0);
        check("rst_rsp_valid", {63'b0, rsp_valid}, 64'd0);
        check("rst_rsp_id", {63'b0, rsp_id}, 64'd0);
        check("rst_rsp_data", rsp_data, 64'd0);
        post_rst = 1'b0;
      end
      check("busy", {63'b0, busy}, {63'b0, m_inflight});
      e0 = !m_inflight && req0_valid && (!req1_valid || m_last);
      e1 = !m_inflight && req1_valid && (!req0_valid || !m_last);
      check("req_ready", {62'b0, req0_ready, req1_ready}, {62'b0, e0, e1});
      if (rsp_valid) begin
        if (sb.size() == 0) begin
          check("rsp_spurious", {63'b0, rsp_valid}, 64'd0);
        end else begin
          if (!sb[0].seen) begin
            check("rsp_latency", 64'(cyc), 64'(sb[0].due));
            sb[0].seen = 1'b1;
          end
          check("rsp_id", {63'b0, rsp_id}, {63'b0, sb[0].id});
          check("rsp_data", rsp_data, sb[0].data);
          check("alu_in1_hold", {32'b0, alu_in1}, {32'b0, sb[0].a});
          check("alu_instr_hold", {48'b0, alu_instructions}, {48'b0, sb[0].op});
          if (rsp_ready) begin
            void'(sb.pop_front());
            m_inflight = 1'b0;
          end
        end
      end else if (sb.size() > 0 && !sb[0].seen && cyc >= sb[0].due) begin
        check("rsp_late", {63'b0, rsp_valid}, 64'd1);
        sb[0].seen = 1'b1;
      end
      if (e0 || e1) begin
        en.id   = e1;
        en.a    = e1 ? req1_in1 : req0_in1;
        en.op   = e1 ? req1_op : req0_op;
        en.data = e1 ? aluf(req1_in1, req1_in2, req1_op) : aluf(req0_in1, req0_in2, req0_op);
        en.due  = cyc + (is_long(en.op) ? DW + 1 : 2);
        en.seen = 1'b0;
        sb.push_back(en);
        m_inflight = 1'b1;
        m_last     = e1;
      end
    end
  end

  task automatic set_req(input int id, input logic [31:0] a, input logic [31:0] b,
                         input logic [15:0] op);
    if (id == 0) begin
      req0_valid = 1'b1; req0_in1 = a; req0_in2 = b; req0_op = op;
    end else begin
      req1_valid = 1'b1; req1_in1 = a; req1_in2 = b; req1_op = op;
    end
  endtask

  task automatic wait_acc(input int id);
    bit done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (id == 0) done = req0_valid && req0_ready;
      else         done = req1_valid && req1_ready;
    end
    check("accept_timeout", {63'b0, done}, 64'd1);
    @(posedge clk); #1;
    if (id == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      done = (sb.size() == 0) && !busy && !rsp_valid;
    end
    check("idle_timeout", {63'b0, done}, 64'd1);
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  function automatic logic [15:0] rnd_op();
    case ($urandom_range(0, 11))
      0: return 16'd1;    1: return 16'd2;    2: return 16'd4;
      3: return 16'd8;    4: return 16'd16;   5: return 16'd32;
      6: return 16'd1024; 7: return 16'd2048; 8: return 16'd4096;
      9: return 16'd3;    10: return 16'd0;
      default: return 16'($urandom);
    endcase
  endfunction

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 3))
      0: return 32'd0;
      1: return 32'($urandom_range(0, 255));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    bit a0, a1, seen;
    rst = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
    req0_in1 = '0; req0_in2 = '0; req0_op = '0;
    req1_in1 = '0; req1_in2 = '0; req1_op = '0;
    @(posedge clk);
    do_reset(2);

    // Single add
    set_req(0, 32'd5, 32'd7, 16'd1);
    wait_acc(0);
    wait_idle();

    // Tie right after reset: req0 first, then req1
    do_reset(1);
    set_req(0, 32'd10, 32'd3, 16'd2);
    set_req(1, 32'hF0, 32'h3C, 16'd16);
    wait_acc(0);
    wait_acc(1);
    wait_idle();

    // Long ops
    set_req(0, 32'd100, 32'd7, 16'd2048);
    wait_acc(0);
    wait_idle();
    set_req(0, 32'd100, 32'd7, 16'd4096);
    wait_acc(0);
    wait_idle();

    // Backpressure for three RESP cycles with req1 waiting
    rsp_ready = 1'b0;
    set_req(0, 32'd20, 32'd22, 16'd1);
    wait_acc(0);
    set_req(1, 32'h55, 32'h0F, 16'd8);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = rsp_valid;
    end
    check("bp_rsp_timeout", {63'b0, seen}, 64'd1);
    repeat (2) @(negedge clk);
    @(posedge clk); #1 rsp_ready = 1'b1;
    wait_acc(1);
    wait_idle();

    // Reset two cycles into a divide
    set_req(0, 32'd100, 32'd7, 16'd2048);
    wait_acc(0);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;

    // Invalid op from req1
    set_req(1, 32'd9, 32'd9, 16'd3);
    wait_acc(1);
    wait_idle();

    // Randomized traffic with random backpressure and payload churn
    for (int t = 0; t < 1500; t++) begin
      @(negedge clk);
      a0 = req0_valid && req0_ready;
      a1 = req1_valid && req1_ready;
      @(posedge clk); #1;
      if (a0) req0_valid = 1'b0;
      else if (!req0_valid && $urandom_range(0, 2) == 0) set_req(0, rnd_val(), rnd_val(), rnd_op());
      else if (req0_valid && $urandom_range(0, 3) == 0) set_req(0, rnd_val(), rnd_val(), rnd_op());
      if (a1) req1_valid = 1'b0;
      else if (!req1_valid && $urandom_range(0, 2) == 0) set_req(1, rnd_val(), rnd_val(), rnd_op());
      else if (req1_valid && $urandom_range(0, 3) == 0) set_req(1, rnd_val(), rnd_val(), rnd_op());
      rsp_ready = ($urandom_range(0, 3) != 0);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready  = 1'b1;
    wait_idle();
    check("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have parameter DIV_WAIT, default 4, legal range 1..16: the number of EXEC cycles used for long ops (1024, 2048, 4096).
REQ-002 The block SHALL use one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 req0_valid, req1_valid  input  1  requester N presents an operation.
REQ-006 req0_ready, req1_ready  output  1  requester N accepted this cycle.
REQ-007 req0_in1, req0_in2, req1_in1, req1_in2  input  32  operands.
REQ-008 req0_op, req1_op  input  16  one-hot ALU selection code, same encoding as the ALU instructions input.
REQ-009 alu_in1, alu_in2  output  32  registered operands driven to the shared ALU.
REQ-010 alu_instructions  output  16  registered op code driven to the shared ALU.
REQ-011 alu_result  input  64  combinational ALU output.
REQ-012 rsp_valid  output  1  response available.
REQ-013 rsp_ready  input  1  consumer takes the response.
REQ-014 rsp_id  output  1  requester index owning the response.
REQ-015 rsp_data  output  64  captured ALU result.
REQ-016 busy  output  1  high in every state except IDLE.

Function
REQ-017 The FSM SHALL have three states: IDLE, EXEC, RESP.
REQ-018 grant0 SHALL be req0_valid && (!req1_valid || last==1); grant1 SHALL be req1_valid && (!req0_valid || last==0).
REQ-019 reqN_ready SHALL be (state==IDLE) && grantN; ready is combinational and never high without the matching valid.
REQ-020 On an accept (valid && ready), the block SHALL register in1/in2/op into alu_in1/alu_in2/alu_instructions, record the owner, set last to the owner, and go to EXEC.
REQ-021 On entering EXEC, the block SHALL load the counter with DIV_WAIT for ops 1024/2048/4096 and with 1 for every other code, including invalid codes.
REQ-022 In EXEC the counter SHALL decrement each cycle; on the cycle it equals 1, the block SHALL capture alu_result into rsp_data and go to RESP.
REQ-023 Latency, counting the accept cycle as 0: rsp_valid SHALL be high at cycle 2 for short ops and at cycle DIV_WAIT+1 for long ops.
REQ-024 In RESP, rsp_valid SHALL be 1 and rsp_id SHALL equal the owner.
REQ-025 rsp_data, rsp_id and the alu_* outputs SHALL hold stable while rsp_valid && !rsp_ready.
REQ-026 When rsp_valid && rsp_ready, the next state SHALL be IDLE; a new accept is possible at the earliest in the cycle after the handshake (no same-cycle turnaround).
REQ-027 alu_* outputs SHALL hold their last values in IDLE.
REQ-028 Op codes SHALL pass through unmodified: invalid codes and divide-by-zero return whatever the ALU produces, with no error flag.
REQ-029 Requesters SHALL hold valid and payload until ready; the block does not check this.
REQ-030 Payload changes on a requester that is not granted SHALL have no effect.
REQ-031 At most one operation SHALL be in flight; no queuing.

Reset
REQ-032 On rst, the block SHALL set state=IDLE, last=1 (req0 wins the first tie), counter=0, rsp_valid=0, rsp_id=0, rsp_data=0, alu_in1=0, alu_in2=0, alu_instructions=0, busy=0.
REQ-033 Reset in EXEC or RESP SHALL abandon the operation: no response is ever emitted for it, and req ready is 0 during the reset cycle.
REQ-034 Reset SHALL take priority over any simultaneous handshake.

Verification
REQ-035 Single add: req0 in1=5, in2=7, op=1 -> req0_ready at cycle 0, rsp_valid at cycle 2, rsp_id=0, rsp_data=12.
REQ-036 Tie after reset: both valid; req0 carries 10-3 with op=2, req1 carries 0xF0&0x3C with op=16 -> req0 is served first (data 7), then req1 (data 0x30, id 1); req1 is not accepted before req0's response handshake.
REQ-037 Long op with DIV_WAIT=4: 100/7 op=2048 -> rsp_valid at cycle 5, data 14; 100%7 op=4096 -> data 2; busy is high from cycle 1 until the response handshake.
REQ-038 Backpressure: rsp_ready held low for 3 cycles during RESP -> rsp_valid, rsp_data and rsp_id are stable and both req ready stay 0 while req1_valid is high; req1 is accepted the cycle after rsp_ready rises.
REQ-039 Reset mid-op: rst pulsed at cycle 2 of a DIV_WAIT=4 divide -> next cycle busy=0, alu_instructions=0, rsp_valid=0; no response appears afterwards.
REQ-040 Invalid op 3 from req1 -> normal 2-cycle response with rsp_id=1 and rsp_data=0.
